// File: rtl/video_timing_ctrl.sv
// Raster timing generator: h/v position counters with a registered decode of sync, data enable and pixel coordinates.
// Define VIDEO_TIMING_CTRL_EXT_SYNC_EN to let ext_sync restart the frame; by default it is ignored.
`timescale 1ns/1ps
module video_timing_ctrl #(
  parameter int video_hlength   = 800,
  parameter int video_vlength   = 525,
  parameter int video_hsync_pol = 0,
  parameter int video_hsync_len = 96,
  parameter int video_hbp_len   = 48,
  parameter int video_h_visible = 640,
  parameter int video_vsync_pol = 0,
  parameter int video_vsync_len = 2,
  parameter int video_vbp_len   = 33,
  parameter int video_v_visible = 480
) (
  input  logic        pixel_clock,
  input  logic        rst,
  input  logic        ext_sync,
  output logic [13:0] timing_h_pos,
  output logic [13:0] timing_v_pos,
  output logic [13:0] pixel_x,
  output logic [13:0] pixel_y,
  output logic        video_vsync,
  output logic        video_hsync,
  output logic        video_den,
  output logic        video_line_start
);

  localparam logic [13:0] H_LAST     = 14'(video_hlength - 1);
  localparam logic [13:0] V_LAST     = 14'(video_vlength - 1);
  localparam logic [13:0] H_SYNC_END = 14'(video_hsync_len);
  localparam logic [13:0] V_SYNC_END = 14'(video_vsync_len);
  localparam logic [13:0] H_ACT_BEG  = 14'(video_hsync_len + video_hbp_len);
  localparam logic [13:0] V_ACT_BEG  = 14'(video_vsync_len + video_vbp_len);
  localparam logic [13:0] H_ACT_END  = 14'(video_hsync_len + video_hbp_len + video_h_visible);
  localparam logic [13:0] V_ACT_END  = 14'(video_vsync_len + video_vbp_len + video_v_visible);
  localparam logic        HSYNC_ON   = (video_hsync_pol != 0);
  localparam logic        VSYNC_ON   = (video_vsync_pol != 0);

  logic [13:0] h_cnt;
  logic [13:0] v_cnt;
  logic        restart;
  logic        h_sync_act;
  logic        v_sync_act;
  logic        h_act;
  logic        v_act;
  logic        den_nxt;

`ifdef VIDEO_TIMING_CTRL_EXT_SYNC_EN
  assign restart = ext_sync;
`else
  logic unused_ext_sync;
  assign unused_ext_sync = ext_sync;
  assign restart         = 1'b0;
`endif

  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (restart) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 14'd0 : v_cnt + 14'd1;
    end else begin
      h_cnt <= h_cnt + 14'd1;
    end
  end

  // Decode works on the current counter value so the registered outputs and timing_*_pos stay aligned.
  always_comb begin
    h_sync_act = (h_cnt < H_SYNC_END);
    v_sync_act = (v_cnt < V_SYNC_END);
    h_act      = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    v_act      = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    den_nxt    = h_act && v_act;
  end

  always_ff @(posedge pixel_clock) begin
    if (rst) begin
      timing_h_pos     <= '0;
      timing_v_pos     <= '0;
      pixel_x          <= '0;
      pixel_y          <= '0;
      video_hsync      <= ~HSYNC_ON;
      video_vsync      <= ~VSYNC_ON;
      video_den        <= 1'b0;
      video_line_start <= 1'b0;
    end else begin
      timing_h_pos     <= h_cnt;
      timing_v_pos     <= v_cnt;
      pixel_x          <= den_nxt ? (h_cnt - H_ACT_BEG) : 14'd0;
      pixel_y          <= den_nxt ? (v_cnt - V_ACT_BEG) : 14'd0;
      video_hsync      <= h_sync_act ? HSYNC_ON : ~HSYNC_ON;
      video_vsync      <= v_sync_act ? VSYNC_ON : ~VSYNC_ON;
      video_den        <= den_nxt;
      video_line_start <= (h_cnt == 14'd0);
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: default-parameter instance checked against a position table and hand sequences,
// plus a small-raster instance under random rst/ext_sync, both compared every clock to a time-based reference model.
`timescale 1ns/1ps
module tb_video_timing_ctrl;

  typedef struct packed {
    logic [13:0] h;
    logic [13:0] v;
    logic [13:0] x;
    logic [13:0] y;
    logic        hs;
    logic        vs;
    logic        den;
    logic        ls;
  } out_t;

  typedef struct {
    int hl; int vl; int hpol; int hsl; int hbp; int hvis; int vpol; int vsl; int vbp; int vvis;
  } cfg_t;

  typedef struct {
    string  name;
    longint t;
    out_t   e;
  } vec_t;

`ifdef VIDEO_TIMING_CTRL_EXT_SYNC_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  localparam int S_HL = 20, S_VL = 12, S_HSL = 3, S_HBP = 2, S_HVIS = 10;
  localparam int S_VSL = 2, S_VBP = 2, S_VVIS = 6, S_HPOL = 1, S_VPOL = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, ext_d, rst_s, ext_s;
  logic [13:0] hd, vd, xd, yd, hs_pos, vs_pos, xs, ys;
  logic hsd, vsd, dend, lsd, hss, vss, dens, lss;
  out_t act_d, act_s;
  assign act_d = {hd, vd, xd, yd, hsd, vsd, dend, lsd};
  assign act_s = {hs_pos, vs_pos, xs, ys, hss, vss, dens, lss};

  video_timing_ctrl dut_d (
    .pixel_clock(clk), .rst(rst_d), .ext_sync(ext_d),
    .timing_h_pos(hd), .timing_v_pos(vd), .pixel_x(xd), .pixel_y(yd),
    .video_vsync(vsd), .video_hsync(hsd), .video_den(dend), .video_line_start(lsd)
  );

  video_timing_ctrl #(
    .video_hlength(S_HL), .video_vlength(S_VL), .video_hsync_pol(S_HPOL),
    .video_hsync_len(S_HSL), .video_hbp_len(S_HBP), .video_h_visible(S_HVIS),
    .video_vsync_pol(S_VPOL), .video_vsync_len(S_VSL), .video_vbp_len(S_VBP),
    .video_v_visible(S_VVIS)
  ) dut_s (
    .pixel_clock(clk), .rst(rst_s), .ext_sync(ext_s),
    .timing_h_pos(hs_pos), .timing_v_pos(vs_pos), .pixel_x(xs), .pixel_y(ys),
    .video_vsync(vss), .video_hsync(hss), .video_den(dens), .video_line_start(lss)
  );

  int     n_pass = 0, n_total = 0;
  cfg_t   cfg_d, cfg_s;
  longint pos_d = 0, pos_s = 0, last_pos_d = -1;
  bit     rand_s = 0, count_s = 0;
  int     cnt_cyc_s = 0, den_cnt_s = 0, ls_cnt_s = 0;
  vec_t   tbl[$];

  function automatic out_t mk(int h, int v, int x, int y, bit hs, bit vs, bit den, bit ls);
    out_t o;
    o.h = 14'(h); o.v = 14'(v); o.x = 14'(x); o.y = 14'(y);
    o.hs = hs; o.vs = vs; o.den = den; o.ls = ls;
    return o;
  endfunction

  // Position is just "clocks since the last restart": h and v fall out of div/mod.
  function automatic out_t model_out(cfg_t c, longint pos);
    out_t o;
    int h, v, hs0, vs0;
    bit ha, va, hsa, vsa;
    h   = int'(pos % longint'(c.hl));
    v   = int'((pos / longint'(c.hl)) % longint'(c.vl));
    hs0 = c.hsl + c.hbp;
    vs0 = c.vsl + c.vbp;
    ha  = (h >= hs0) && (h < hs0 + c.hvis);
    va  = (v >= vs0) && (v < vs0 + c.vvis);
    hsa = (h < c.hsl);
    vsa = (v < c.vsl);
    o.h   = 14'(h);
    o.v   = 14'(v);
    o.den = ha && va;
    o.x   = o.den ? 14'(h - hs0) : 14'd0;
    o.y   = o.den ? 14'(v - vs0) : 14'd0;
    o.hs  = (c.hpol != 0) ? hsa : !hsa;
    o.vs  = (c.vpol != 0) ? vsa : !vsa;
    o.ls  = (h == 0);
    return o;
  endfunction

  function automatic out_t reset_out(cfg_t c);
    out_t o;
    o    = '0;
    o.hs = (c.hpol == 0);
    o.vs = (c.vpol == 0);
    return o;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("h=%0d v=%0d x=%0d y=%0d hs=%0b vs=%0b den=%0b ls=%0b",
                     o.h, o.v, o.x, o.y, o.hs, o.vs, o.den, o.ls);
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    else n_pass++;
  endtask

  task automatic check_int(input string name, input longint act, input longint exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    out_t ed, es;
    @(posedge clk);
    if (rst_d) begin
      ed = reset_out(cfg_d); pos_d = 0; last_pos_d = -1;
    end else begin
      ed = model_out(cfg_d, pos_d); last_pos_d = pos_d;
      pos_d = (ext_d && EXT_EN) ? 0 : pos_d + 1;
    end
    if (rst_s) begin
      es = reset_out(cfg_s); pos_s = 0;
    end else begin
      es = model_out(cfg_s, pos_s);
      pos_s = (ext_s && EXT_EN) ? 0 : pos_s + 1;
    end
    @(negedge clk);
    check_out("model_d", act_d, ed);
    check_out("model_s", act_s, es);
    if (count_s) begin
      den_cnt_s += int'(dens);
      ls_cnt_s  += int'(lss);
      cnt_cyc_s++;
      if (cnt_cyc_s == S_HL * S_VL) begin count_s = 0; rand_s = 1; end
    end
    if (rand_s) begin
      rst_s = ($urandom_range(0, 149) == 0);
      ext_s = ($urandom_range(0, 79) == 0);
    end
  endtask

  task automatic run_until_d(input longint target, input string name);
    int g = 0;
    while (last_pos_d != target && g < 50000) begin tick(); g++; end
    check_int(name, last_pos_d, target);
  endtask

  task automatic add(input string n, input longint t, input out_t e);
    vec_t r;
    r.name = n; r.t = t; r.e = e;
    tbl.push_back(r);
  endtask

  initial begin
    cfg_d = '{800, 525, 0, 96, 48, 640, 0, 2, 33, 480};
    cfg_s = '{S_HL, S_VL, S_HPOL, S_HSL, S_HBP, S_HVIS, S_VPOL, S_VSL, S_VBP, S_VVIS};

    // Default raster, active-low syncs: {position since reset, expected outputs}.
    add("first_edge",   0,     mk(0,   0,  0,   0, 0, 0, 0, 1));
    add("second_edge",  1,     mk(1,   0,  0,   0, 0, 0, 0, 0));
    add("hsync_last",   95,    mk(95,  0,  0,   0, 0, 0, 0, 0));
    add("hsync_off",    96,    mk(96,  0,  0,   0, 1, 0, 0, 0));
    add("line_end",     799,   mk(799, 0,  0,   0, 1, 0, 0, 0));
    add("line1_start",  800,   mk(0,   1,  0,   0, 0, 0, 0, 1));
    add("vsync_last",   1599,  mk(799, 1,  0,   0, 1, 0, 0, 0));
    add("vsync_off",    1600,  mk(0,   2,  0,   0, 0, 1, 0, 1));
    add("v34_no_den",   27344, mk(144, 34, 0,   0, 1, 1, 0, 0));
    add("v35_start",    28000, mk(0,   35, 0,   0, 0, 1, 0, 1));
    add("h143_no_den",  28143, mk(143, 35, 0,   0, 1, 1, 0, 0));
    add("den_first",    28144, mk(144, 35, 0,   0, 1, 1, 1, 0));
    add("den_last_col", 28783, mk(783, 35, 639, 0, 1, 1, 1, 0));
    add("den_off_fp",   28784, mk(784, 35, 0,   0, 1, 1, 0, 0));
    add("row1_first",   28944, mk(144, 36, 0,   1, 1, 1, 1, 0));

    rst_d = 1; rst_s = 1; ext_d = 0; ext_s = 0;
    repeat (3) tick();
    check_out("reset_vals_d", act_d, mk(0, 0, 0, 0, 1, 1, 0, 0));
    check_out("reset_vals_s", act_s, mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_d = 0; rst_s = 0; count_s = 1;

    for (int k = 0; k < tbl.size(); k++) begin
      run_until_d(tbl[k].t, {tbl[k].name, "_reach"});
      check_out(tbl[k].name, act_d, tbl[k].e);
    end
    check_int("s_den_per_frame", den_cnt_s, S_HVIS * S_VVIS);
    check_int("s_ls_per_frame", ls_cnt_s, S_VL);

    // Reset pulse landing on h=300 of line 36.
    run_until_d(36 * 800 + 299, "rst_reach");
    rst_d = 1;
    tick(); check_out("rst_hold0", act_d, mk(0, 0, 0, 0, 1, 1, 0, 0));
    tick(); check_out("rst_hold1", act_d, mk(0, 0, 0, 0, 1, 1, 0, 0));
    rst_d = 0;
    tick(); check_out("rst_restart", act_d, mk(0, 0, 0, 0, 0, 0, 0, 1));
    tick(); check_out("rst_restart_p1", act_d, mk(1, 0, 0, 0, 0, 0, 0, 0));

    // ext_sync seen at the edge showing h=100, v=1.
    run_until_d(899, "ext_reach");
    ext_d = 1;
    tick(); check_out("ext_edge", act_d, mk(100, 1, 0, 0, 1, 0, 0, 0));
    ext_d = 0;
    tick();
    check_out("ext_after", act_d, EXT_EN ? mk(0, 0, 0, 0, 0, 0, 0, 1) : mk(101, 1, 0, 0, 1, 0, 0, 0));
    tick();
    check_out("ext_after_p1", act_d, EXT_EN ? mk(1, 0, 0, 0, 0, 0, 0, 0) : mk(102, 1, 0, 0, 1, 0, 0, 0));

    repeat (2000) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
